// File: rtl/ct_arbiter_if.sv
// Requester-side bundle of the ciphertext ROM arbiter: per-requester request,
// lock and address, plus the returned grant, read-valid strobes and shared data.
interface ct_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [1:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, lock, addr0, addr1,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, addr0, addr1,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ct_arbiter.sv
// Two-port round-robin arbiter for the single read port of ct_mem, with
// per-requester lock for exclusive bursts and a registered per-requester valid.
module ct_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ct_arbiter_if.slave       bus,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  gnt;
  logic [1:0]  lock_gnt;

  always_comb begin
    gnt      = 2'b00;
    lock_gnt = 2'b00;
    state_d  = state_q;
    last_d   = last_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // On a tie the requester that was not served last wins.
          if (bus.req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
          end else begin
            gnt = bus.req;
          end
          lock_gnt = gnt & bus.lock;
          if (lock_gnt[0]) begin
            state_d = OWN0;
          end else if (lock_gnt[1]) begin
            state_d = OWN1;
          end
        end
        OWN0: begin
          gnt = {1'b0, bus.req[0]};
          if (!bus.lock[0]) begin
            state_d = IDLE;
          end
        end
        OWN1: begin
          gnt = {bus.req[1], 1'b0};
          if (!bus.lock[1]) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      if (gnt[0]) begin
        last_d = 1'b0;
      end else if (gnt[1]) begin
        last_d = 1'b1;
      end
    end
    rvalid_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  // ct_mem returns data one cycle after the address, aligned with rvalid_q.
  assign mem_addr   = gnt[1] ? bus.addr1 : bus.addr0;
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = mem_q;

endmodule

// File: tb/tb_ct_arbiter.sv
// Scoreboard bench for ct_arbiter: behavioural grant model, ROM model and a
// decoupled monitor checking the delayed rvalid/rdata stream.
module tb_ct_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;

  ct_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ct_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) mem_q <= rom[mem_addr];

  typedef struct {
    int                due;
    logic [1:0]        id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] prev_gnt = 2'b00;

  // Reference model: owner is -1 when nobody holds the port exclusively.
  int   m_owner = -1;
  int   m_last  = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Model side: predict this cycle's grant and queue the read it should return.
  always @(negedge clk) begin
    int   winner;
    logic [1:0] g;
    exp_t e;
    winner = -1;
    if (rst) begin
      winner = -1;
    end else if (m_owner >= 0) begin
      if (bus.req[m_owner]) winner = m_owner;
    end else if (bus.req[0] && bus.req[1]) begin
      winner = 1 - m_last;
    end else if (bus.req[0]) begin
      winner = 0;
    end else if (bus.req[1]) begin
      winner = 1;
    end
    g = (winner < 0) ? 2'b00 : 2'(1 << winner);

    checks++;
    if (bus.gnt !== g) begin
      failures++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, g);
    end
    if (winner >= 0) begin
      checks++;
      if (mem_addr !== (winner == 1 ? bus.addr1 : bus.addr0)) begin
        failures++;
        $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr,
                 (winner == 1 ? bus.addr1 : bus.addr0));
      end
      e.due  = cyc + 1;
      e.id   = g;
      e.data = rom[winner == 1 ? bus.addr1 : bus.addr0];
      exp_q.push_back(e);
    end

    if (rst) begin
      m_owner = -1;
      m_last  = 1;
    end else begin
      if (winner >= 0) m_last = winner;
      if (m_owner >= 0) begin
        if (!bus.lock[m_owner]) m_owner = -1;
      end else if (winner >= 0 && bus.lock[winner]) begin
        m_owner = winner;
      end
    end
    prev_gnt = bus.gnt;
  end

  // Monitor: every cycle the valid strobe must match the read due now, if any.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.rvalid !== e.id || bus.rdata !== e.data) begin
        failures++;
        $display("FAIL rdata cyc=%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                 cyc, bus.rvalid, bus.rdata, e.id, e.data);
      end
    end else if (cyc > 0) begin
      checks++;
      if (bus.rvalid !== 2'b00) begin
        failures++;
        $display("FAIL rvalid_idle cyc=%0d got=%b exp=00", cyc, bus.rvalid);
      end
    end
  end

  task automatic step(input logic [1:0] r, input logic [1:0] l,
                      input logic [7:0] a0, input logic [7:0] a1, input logic rs);
    bus.req   = r;
    bus.lock  = l;
    bus.addr0 = a0;
    bus.addr1 = a1;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] r;
    logic [7:0] a0, a1;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom);
    rom[8'h05] = 8'hA3;
    bus.req = 2'b00; bus.lock = 2'b00; bus.addr0 = '0; bus.addr1 = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Single requester
    step(2'b01, 2'b00, 8'h05, 8'h00, 1'b0);
    step(2'b00, 2'b00, 8'h05, 8'h00, 1'b0);

    // Contention after reset
    step(2'b00, 2'b00, 8'h10, 8'h20, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 8'h10, 8'h20, 1'b0);
    step(2'b00, 2'b00, 8'h10, 8'h20, 1'b0);

    // Lock burst by requester 1 while requester 0 waits
    step(2'b01, 2'b00, 8'h30, 8'h00, 1'b0);
    step(2'b11, 2'b10, 8'h30, 8'h00, 1'b0);
    step(2'b11, 2'b10, 8'h30, 8'h01, 1'b0);
    step(2'b11, 2'b00, 8'h30, 8'h02, 1'b0);
    step(2'b01, 2'b00, 8'h30, 8'h02, 1'b0);
    step(2'b00, 2'b00, 8'h30, 8'h02, 1'b0);

    // Idle gap inside an OWN0 burst
    step(2'b01, 2'b01, 8'h40, 8'h50, 1'b0);
    step(2'b10, 2'b01, 8'h41, 8'h50, 1'b0);
    step(2'b10, 2'b01, 8'h41, 8'h50, 1'b0);
    step(2'b11, 2'b00, 8'h42, 8'h50, 1'b0);
    step(2'b10, 2'b00, 8'h42, 8'h50, 1'b0);

    // Reset in the middle of an OWN1 burst
    step(2'b10, 2'b10, 8'h60, 8'h70, 1'b0);
    step(2'b10, 2'b10, 8'h60, 8'h71, 1'b1);
    step(2'b11, 2'b00, 8'h60, 8'h72, 1'b0);
    step(2'b10, 2'b00, 8'h60, 8'h72, 1'b0);

    // Stray lock on an ungranted requester
    step(2'b01, 2'b10, 8'h80, 8'h90, 1'b0);
    step(2'b11, 2'b00, 8'h81, 8'h90, 1'b0);
    step(2'b01, 2'b00, 8'h81, 8'h90, 1'b0);
    step(2'b00, 2'b00, 8'h81, 8'h90, 1'b0);

    // Random traffic honouring the hold-until-granted rule
    r = 2'b00; a0 = '0; a1 = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(r[0] && !prev_gnt[0])) begin
        r[0] = 1'($urandom);
        a0   = 8'($urandom);
      end
      if (!(r[1] && !prev_gnt[1])) begin
        r[1] = 1'($urandom);
        a1   = 8'($urandom);
      end
      step(r, {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
           a0, a1, ($urandom_range(0, 99) == 0));
    end
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
